div_sched: RTL
==============

Name: div_sched

Overview:
- EX-stage controller that sequences the iterative divider for DIV/DIVU.
- Captures the operands and drives the divider's start/signed/annul handshake.
- Generates the pipeline stall, holds the result while later stages are stalled, and issues exactly one HI/LO write per committed divide.
- Adds divide-by-zero short-circuit and a hang watchdog.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH as {HI,LO}.
- TIMEOUT_CYC, 40, maximum BUSY cycles before the watchdog forces completion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid_i  in  1  EX holds a divide instruction
- op_signed_i  in  1  1=DIV, 0=DIVU
- a_i  in  WIDTH  dividend (rs)
- b_i  in  WIDTH  divisor (rt)
- flush_i  in  1  exception/flush; kills any in-flight divide
- pipe_stall_i  in  1  stall from other sources (e.g. memory); EX cannot advance
- div_start_o  out  1  level start to divider
- div_signed_o  out  1  signed select to divider
- div_opa_o  out  WIDTH  latched dividend
- div_opb_o  out  WIDTH  latched divisor
- div_annul_o  out  1  abort divider
- div_result_i  in  2*WIDTH  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid (1-cycle pulse)
- stall_o  out  1  request EX/earlier stages to hold
- hilo_we_o  out  1  HI/LO write enable
- hilo_wdata_o  out  2*WIDTH  {HI=remainder, LO=quotient}
- timeout_o  out  1  1-cycle pulse when the watchdog fired

Behaviour:
- Reset: synchronous, active-high.
  - All outputs 0; state IDLE; operand latches and counter 0.
  - Reset mid-operation abandons the divide with no write.
- IDLE:
  - On op_valid_i & ~flush_i, latch a_i, b_i and op_signed_i; stall_o=1 combinationally in this same cycle.
  - If b_i==0, go to DONE with result {HI=a_i, LO=all ones}; the divider is not started.
  - Otherwise go to BUSY.
- BUSY:
  - div_start_o=1, div_signed_o=latched sign, div_opa_o/div_opb_o=latched operands, all stable throughout.
  - stall_o=1.
  - The cycle counter increments each cycle.
  - On div_ready_i, capture div_result_i and go to DONE.
  - If the counter reaches TIMEOUT_CYC-1 without ready:
    - assert div_annul_o for 1 cycle;
    - pulse timeout_o;
    - set result to 0;
    - go to DONE.
- DONE:
  - div_start_o=0; the result is held.
  - stall_o=pipe_stall_i, so the instruction advances when no other stall is present.
  - hilo_we_o=~pipe_stall_i, with hilo_wdata_o=held result; the write occurs only in the cycle the instruction leaves EX.
  - On ~pipe_stall_i, go to IDLE; otherwise stay in DONE.
  - op_valid_i still high in DONE never restarts the divide.
- IDLE next cycle: a new op_valid_i is treated as a new divide. Back-to-back divides are legal.
- Latency: divider latency + 2 cycles (1 issue + 1 DONE). Divide-by-zero takes 2 cycles.
- flush_i:
  - Highest priority in every state.
  - Next state is IDLE; hilo_we_o=0 that cycle.
  - If BUSY, div_annul_o=1 for that cycle and div_start_o=0.
  - flush_i together with div_ready_i: flush wins, the result is discarded.
  - flush_i in DONE: no write.
- Signed overflow (-2^31 / -1): passed to the divider unchanged; no special case.
- div_annul_o is never asserted outside BUSY.

Decomposition:
- Shared package defines:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the div-by-zero result constants.
- One sub-module, div_watchdog: counter with clear/enable, producing an expire pulse at TIMEOUT_CYC-1.
- The divider itself stays external.

Test Plan:
- DIVU a=100, b=7; divider ready after 33 cycles:
  - one hilo_we_o pulse with {HI=2, LO=14};
  - stall_o high from the issue cycle until the DONE cycle.
- DIV a=-7 (0xFFFFFFF9), b=2: div_signed_o=1 throughout BUSY; write {HI=0xFFFFFFFF, LO=0xFFFFFFFD}.
- DIVU a=5, b=0:
  - div_start_o never asserted;
  - DONE on cycle 2; write {HI=5, LO=0xFFFFFFFF}.
- flush_i in BUSY cycle 10:
  - div_annul_o pulse, IDLE next cycle;
  - a later div_ready_i produces no write;
  - the following divide completes correctly.
- pipe_stall_i high for 5 cycles in DONE:
  - hilo_we_o stays 0 and stall_o stays 1 for those 5 cycles;
  - exactly one write in the first unstalled cycle;
  - op_valid_i held high causes no restart.
- div_ready_i never asserted:
  - at BUSY cycle 39, div_annul_o and timeout_o pulse;
  - write of 0 on the DONE exit cycle.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared constants for the EX-stage divide scheduler: FSM encoding and
// the fixed result produced when the divisor is zero.
package div_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide by zero: HI takes the dividend, every LO bit is set to this value.
  localparam logic DIV0_LO_FILL = 1'b1;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_TIMEOUT_CYC = 40;

endpackage

// File: rtl/div_sched_if.sv
// Handshake bundle between the divide scheduler (master) and the external
// iterative divider (slave).
interface div_sched_if #(
  parameter int WIDTH = 32
);
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_opa;
  logic [WIDTH-1:0]   div_opb;
  logic               div_annul;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;

  modport master (
    output div_start, div_signed, div_opa, div_opb, div_annul,
    input  div_result, div_ready
  );

  modport slave (
    input  div_start, div_signed, div_opa, div_opb, div_annul,
    output div_result, div_ready
  );
endinterface

// File: rtl/div_sched_watchdog.sv
// Busy-cycle counter; o_expire flags the last permitted cycle while enabled.
module div_watchdog #(
  parameter int TIMEOUT_CYC = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/div_sched.sv
// EX-stage divide controller: captures operands, runs the external divider,
// stalls the pipe and issues one HI/LO write per committed divide.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic               op_signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               flush_i,
  input  logic               pipe_stall_i,
  div_sched_if.master        div,
  output logic               stall_o,
  output logic               hilo_we_o,
  output logic [2*WIDTH-1:0] hilo_wdata_o,
  output logic               timeout_o
);
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_signed;
  logic [2*WIDTH-1:0] r_result;

  logic w_idle, w_busy, w_done;
  logic w_issue, w_b_zero, w_ready_hit, w_expire, w_expire_hit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy   = (r_state == ST_BUSY);
  assign w_done   = (r_state == ST_DONE);
  assign w_b_zero = (b_i == '0);
  assign w_issue  = w_idle && op_valid_i && !flush_i;

  // A ready pulse in the expiry cycle still counts as a normal completion.
  assign w_ready_hit  = w_busy && !flush_i && div.div_ready;
  assign w_expire_hit = w_busy && !flush_i && !div.div_ready && w_expire;

  div_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_busy),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (op_valid_i) w_state_next = w_b_zero ? ST_DONE : ST_BUSY;
        ST_BUSY: if (w_ready_hit || w_expire_hit) w_state_next = ST_DONE;
        ST_DONE: if (!pipe_stall_i) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_signed <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_opa    <= a_i;
        r_opb    <= b_i;
        r_signed <= op_signed_i;
        if (w_b_zero) begin
          r_result <= {a_i, {WIDTH{DIV0_LO_FILL}}};
        end
      end
      if (w_ready_hit) begin
        r_result <= div.div_result;
      end else if (w_expire_hit) begin
        r_result <= '0;
      end
    end
  end

  assign div.div_start  = !rst && w_busy && !flush_i;
  assign div.div_signed = r_signed;
  assign div.div_opa    = r_opa;
  assign div.div_opb    = r_opb;
  assign div.div_annul  = !rst && w_busy && (flush_i || w_expire_hit);

  // The instruction leaves EX from DONE only when nothing else holds the pipe.
  assign stall_o      = !rst && (w_issue || w_busy || (w_done && pipe_stall_i));
  assign hilo_we_o    = !rst && w_done && !pipe_stall_i && !flush_i;
  assign hilo_wdata_o = r_result;
  assign timeout_o    = !rst && w_expire_hit;
endmodule
